// File: rtl/mem_wait_ctl_pkg.sv
// Shared CPU bus package: memory-cycle FSM encoding and default bus timeout.
package mem_wait_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_NXM  = 2'd2
  } mwc_state_e;

  localparam int unsigned MWC_TIMEOUT_DEF = 255;
  localparam int unsigned MWC_CNTW_DEF    = 8;

endpackage

// File: rtl/mem_wait_ctl.sv
// Memory-cycle wait controller: issues a bus request, stalls the timing block
// until busACK, and aborts with nxmFLAG if no target answers within TIMEOUT.
module mem_wait_ctl
  import mem_wait_ctl_pkg::*;
#(
  parameter int unsigned TIMEOUT = MWC_TIMEOUT_DEF,
  parameter int unsigned CNTW    = MWC_CNTW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic memSTART,
  input  logic memREAD,
  input  logic memWRITE,
  input  logic memIO,
  input  logic busACK,
  output logic busREQ,
  output logic busREAD,
  output logic busWRITE,
  output logic busIO,
  output logic memWAIT,
  output logic memDONE,
  output logic nxmFLAG
);

  localparam logic [CNTW-1:0] LP_LAST = CNTW'(TIMEOUT - 1);

  mwc_state_e      r_state, w_state_nx;
  logic [CNTW-1:0] r_cnt,   w_cnt_nx;
  logic            r_req,   w_req_nx;
  logic            r_rd,    w_rd_nx;
  logic            r_wr,    w_wr_nx;
  logic            r_io,    w_io_nx;
  logic            r_wait,  w_wait_nx;
  logic            r_done,  w_done_nx;
  logic            r_nxm,   w_nxm_nx;

  // Outputs are computed alongside the next state so every one leaves a flop.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_req_nx   = r_req;
    w_rd_nx    = r_rd;
    w_wr_nx    = r_wr;
    w_io_nx    = r_io;
    w_wait_nx  = r_wait;
    w_done_nx  = 1'b0;
    w_nxm_nx   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (memSTART && (memREAD || memWRITE)) begin
          w_state_nx = ST_BUSY;
          w_cnt_nx   = '0;
          w_req_nx   = 1'b1;
          w_wait_nx  = 1'b1;
          w_rd_nx    = memREAD;
          w_wr_nx    = memWRITE;
          w_io_nx    = memIO;
        end
      end
      ST_BUSY: begin
        // busACK takes priority over the timeout on the same edge.
        if (busACK || (r_cnt == LP_LAST)) begin
          w_state_nx = busACK ? ST_IDLE : ST_NXM;
          w_req_nx   = 1'b0;
          w_rd_nx    = 1'b0;
          w_wr_nx    = 1'b0;
          w_io_nx    = 1'b0;
          w_wait_nx  = 1'b0;
          w_done_nx  = busACK;
          w_nxm_nx   = ~busACK;
        end else if (r_cnt != '1) begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      ST_NXM: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_req_nx   = 1'b0;
        w_rd_nx    = 1'b0;
        w_wr_nx    = 1'b0;
        w_io_nx    = 1'b0;
        w_wait_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_io    <= 1'b0;
      r_wait  <= 1'b0;
      r_done  <= 1'b0;
      r_nxm   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_req   <= w_req_nx;
      r_rd    <= w_rd_nx;
      r_wr    <= w_wr_nx;
      r_io    <= w_io_nx;
      r_wait  <= w_wait_nx;
      r_done  <= w_done_nx;
      r_nxm   <= w_nxm_nx;
    end
  end

  assign busREQ   = r_req;
  assign busREAD  = r_rd;
  assign busWRITE = r_wr;
  assign busIO    = r_io;
  assign memWAIT  = r_wait;
  assign memDONE  = r_done;
  assign nxmFLAG  = r_nxm;

endmodule
